// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
//   Shared definitions for the instruction-fetch stage.
//   RESET_PC_DEF : default boot PC
//   INSTR_NOP    : word presented on instr_data_o while the fetch buffer is empty
//   if_state_e   : fetch controller states
//   word_align() : clears the two low address bits
// ---------------------------------------------------------------------------
package if_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo
//   Fetch buffer holding {instruction word, PC} pairs, DEPTH entries
//   (power of two, >= 2). Head is presented combinationally.
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   push, push_data/pc   : write one entry at the tail
//   pop                  : drop the head entry (ignored when empty)
//   flush                : discard all entries; dominates push/pop
//   head_data, head_pc   : current head entry
//   count                : number of valid entries
//   empty                : count == 0
// ---------------------------------------------------------------------------
module if_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic [31:0]   push_pc,
    input  logic          pop,
    input  logic          flush,
    output logic [31:0]   head_data,
    output logic [31:0]   head_pc,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    assign head_data = data_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            data_mem[wr_ptr] <= push_data;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage: owns the PC, issues word fetches on a req/gnt +
//   rvalid memory port, buffers returned words and hands them to id_stage
//   with valid/ready. Redirects from EX flush the buffer and discard any
//   responses still in flight for the wrong path.
// Parameters
//   RESET_PC   : PC loaded on reset
//   FIFO_DEPTH : fetch-buffer entries (power of two, >= 2)
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   imem_req_o / imem_addr_o      : fetch request and word address
//   imem_gnt_i                    : request accepted this cycle
//   imem_rvalid_i / imem_rdata_i  : in-order response
//   redirect_i / redirect_pc_i    : taken branch/jump target from EX
//   instr_valid_o / instr_ready_i : handshake towards id_stage
//   instr_data_o / instr_pc_o     : buffer head (NOP / 0 when empty)
//   misalign_o                    : sticky misaligned-redirect flag
// Build option
//   IF_MISALIGN_CHK_EN : a redirect with target[1:0] != 0 sets misalign_o and
//                        stops further fetching until reset. Without it the
//                        target is silently word aligned and fetch continues.
// ---------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    output logic        misalign_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    if_state_e     state, state_next;
    logic [31:0]   pc, pc_next;
    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] discard, discard_next;
    logic          misalign;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [31:0]   head_data;
    logic [31:0]   head_pc;

    logic [CW:0]   credit_used;
    logic          grant;
    logic          take;
    logic          drop;
    logic          push;
    logic          pop;
    logic [31:0]   resp_pc;

    // Credits: every granted request owns a buffer slot until it is popped,
    // so the buffer can never overflow.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_o  = (state == RUN) && !misalign && (credit_used < DEPTH_W);
    assign imem_addr_o = pc;
    assign grant       = imem_req_o && imem_gnt_i;

    // discard is only non-zero in DRAIN, where outstanding is zero.
    assign drop = imem_rvalid_i && (discard != '0);
    assign take = imem_rvalid_i && (discard == '0) && (outstanding != '0);

    assign push = take && !redirect_i;
    assign pop  = !fifo_empty && instr_ready_i && !redirect_i;

    // All live requests were issued consecutively since the last redirect,
    // so the oldest one (the one now returning) sits outstanding words
    // behind the current PC. This replaces a per-request PC queue.
    assign resp_pc = pc - 32'({outstanding, 2'b00});

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        outstanding_next = outstanding + CW'(grant) - CW'(take);
        discard_next     = discard;

        if (grant) pc_next = pc + 32'd4;
        if (drop)  discard_next = discard - CW'(1);

        if (redirect_i) begin
            pc_next          = word_align(redirect_pc_i);
            outstanding_next = '0;
            if (state != DRAIN) discard_next = outstanding + CW'(grant) - CW'(take);
        end

        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redirect_i && ((outstanding != '0) || grant)) state_next = DRAIN;
            DRAIN:   if (discard_next == '0) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    logic misalign_next;

    always_comb begin
        misalign_next = misalign;
        if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) misalign_next = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= misalign_next;
    end
`else
    assign misalign = 1'b0;
`endif

    assign misalign_o = misalign;

    if_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(imem_rdata_i),
        .push_pc  (resp_pc),
        .pop      (pop),
        .flush    (redirect_i),
        .head_data(head_data),
        .head_pc  (head_pc),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_data_o  = fifo_empty ? INSTR_NOP : head_data;
    assign instr_pc_o    = fifo_empty ? '0 : head_pc;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage: a queue-based model of the fetch stage
//   and a latency-randomised instruction memory, directed scenarios with
//   literal expectations, then a randomized run. Honours IF_MISALIGN_CHK_EN.
// ---------------------------------------------------------------------------
module tb_if_stage;
    import if_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_data_o;
    logic [31:0] instr_pc_o;
    logic        misalign_o;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_data_o (instr_data_o),
        .instr_pc_o   (instr_pc_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // memory side: granted requests awaiting their response
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          n_grants = 0;
    int          max_inflight = 0;
    logic [31:0] first_grant_addr = '0;

    // reference model
    bit          m_boot, m_drain, m_halt;
    logic [31:0] m_pc;
    int          m_discard;
    logic [31:0] m_inflight[$];
    logic [31:0] m_fd[$];
    logic [31:0] m_fp[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F0F};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    endfunction

    function automatic bit m_req();
        return !m_boot && !m_drain && !m_halt && ((m_inflight.size() + m_fd.size()) < DEPTH);
    endfunction

    function automatic void model_reset();
        m_boot = 1; m_drain = 0; m_halt = 0; m_pc = 32'h0; m_discard = 0;
        m_inflight.delete(); m_fd.delete(); m_fp.delete();
    endfunction

    function automatic void compare_outputs();
        bit er;
        bit ev;
        er = m_req();
        ev = (m_fd.size() > 0);
        chk("req", imem_req_o, er);
        if (er) chk("addr", imem_addr_o, m_pc);
        chk("valid", instr_valid_o, ev);
        chk("data", instr_data_o, ev ? m_fd[0] : INSTR_NOP);
        chk("ipc", instr_pc_o, ev ? m_fp[0] : 32'h0);
        chk("misalign", misalign_o, m_halt);
    endfunction

    function automatic void model_update(input bit g, input bit rv, input logic [31:0] rd,
                                         input bit redir, input logic [31:0] rpc, input bit rdy);
        bit granted;
        int live;
        granted = m_req() && g;
        live    = m_inflight.size();
        m_boot  = 0;
        if (m_drain) begin
            if (rv && m_discard > 0) m_discard--;
            if (redir) begin
                m_pc = rpc & ~32'h3;
`ifdef IF_MISALIGN_CHK_EN
                if (rpc[1:0] != 2'b00) m_halt = 1;
`endif
            end
            if (m_discard == 0) m_drain = 0;
        end else if (redir) begin
            m_discard = live + (granted ? 1 : 0) - ((rv && live > 0) ? 1 : 0);
            m_drain   = (live + (granted ? 1 : 0)) > 0;
            m_inflight.delete(); m_fd.delete(); m_fp.delete();
            m_pc = rpc & ~32'h3;
`ifdef IF_MISALIGN_CHK_EN
            if (rpc[1:0] != 2'b00) m_halt = 1;
`endif
        end else begin
            if (m_fd.size() > 0 && rdy) begin
                void'(m_fd.pop_front());
                void'(m_fp.pop_front());
            end
            if (rv && live > 0) begin
                m_fd.push_back(rd);
                m_fp.push_back(m_inflight.pop_front());
            end
            if (granted) begin
                m_inflight.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    // One clock: check outputs, drive inputs, advance memory and model.
    task automatic step(input bit g, input bit rdy, input bit redir, input logic [31:0] rpc, input int lat);
        bit          rv;
        logic [31:0] rdv;
        compare_outputs();
        rv  = 0;
        rdv = $urandom();
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rv  = 1;
            rdv = memword(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rdv;
        instr_ready_i = rdy; redirect_i = redir; redirect_pc_i = rpc;
        if (imem_req_o && g) begin
            if (n_grants == 0) first_grant_addr = imem_addr_o;
            mq_addr.push_back(imem_addr_o);
            mq_due.push_back(cyc + lat);
            n_grants++;
        end
        if (mq_addr.size() > max_inflight) max_inflight = mq_addr.size();
        model_update(g, rv, rdv, redir, rpc, rdy);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset between edges; responses granted before it still
    // arrive afterwards and must be ignored.
    task automatic do_reset();
        #2 rst = 1'b1;
        imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0; instr_ready_i = 0;
        #1;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_data", instr_data_o, 32'h0000_0013);
        chk("rst_pc", instr_pc_o, 32'h0);
        chk("rst_misalign", misalign_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 40 && mq_addr.size() > 0; i++) step(0, 1, 0, 32'h0, 1);
        n_grants = 0;
        max_inflight = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] obs[$];
        logic [31:0] first_req, first_ipc;
        bit          seen_req, seen_ipc, found;
        int          g0;
        logic [31:0] tgt;

        @(negedge clk);

        // 1: free-running fetch, single-cycle memory, always ready
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (instr_valid_o) obs.push_back(instr_pc_o);
            step(1, 1, 0, 32'h0, 1);
        end
        chk("t1_first_addr", first_grant_addr, 32'h0);
        chk("t1_enough", obs.size() >= 3, 1'b1);
        if (obs.size() >= 3) begin
            chk("t1_pc0", obs[0], 32'h0);
            chk("t1_pc1", obs[1], 32'h4);
            chk("t1_pc2", obs[2], 32'h8);
        end
        chk("t1_max_inflight", max_inflight <= DEPTH, 1'b1);

        // 2: downstream stall fills the buffer and stops fetching
        for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h0, 1);
        chk("t2_req_off", imem_req_o, 1'b0);
        chk("t2_valid", instr_valid_o, 1'b1);
        g0 = n_grants;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h0, 1);
        chk("t2_resume", n_grants > g0, 1'b1);

        // 3: grant withheld, address must hold at 8
        do_reset();
        for (int i = 0; i < 6; i++) step(n_grants < 2, 1, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_req", imem_req_o, 1'b1);
            chk("t3_addr_hold", imem_addr_o, 32'h8);
            step(0, 1, 0, 32'h0, 1);
        end
        step(1, 1, 0, 32'h0, 1);
        chk("t3_addr_next", imem_addr_o, 32'hC);

        // 4: redirect with two responses in flight
        do_reset();
        step(0, 1, 0, 32'h0, 3);
        step(1, 1, 0, 32'h0, 3);
        step(1, 1, 0, 32'h0, 3);
        chk("t4_inflight", mq_addr.size(), 32'd2);
        step(1, 1, 1, 32'h100, 3);
        chk("t4_drain_noreq", imem_req_o, 1'b0);
        seen_req = 0; seen_ipc = 0; first_req = '0; first_ipc = '0;
        for (int i = 0; i < 30 && !(seen_req && seen_ipc); i++) begin
            if (imem_req_o && !seen_req) begin seen_req = 1; first_req = imem_addr_o; end
            if (instr_valid_o && !seen_ipc) begin seen_ipc = 1; first_ipc = instr_pc_o; end
            step(1, 1, 0, 32'h0, 3);
        end
        chk("t4_req_seen", seen_req, 1'b1);
        chk("t4_next_addr", first_req, 32'h100);
        chk("t4_ipc_seen", seen_ipc, 1'b1);
        chk("t4_first_ipc", first_ipc, 32'h100);

        // 5: redirect coincides with a response and a pop
        do_reset();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (instr_valid_o && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                found = 1;
                step(1, 1, 1, 32'h200, 1);
            end else begin
                step(1, 1, 0, 32'h0, 1);
            end
        end
        chk("t5_found", found, 1'b1);
        chk("t5_flushed", instr_valid_o, 1'b0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h0, 1);

        // 6: misaligned redirect target
        do_reset();
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 1, 32'h102, 1);
`ifdef IF_MISALIGN_CHK_EN
        chk("t6_misalign", misalign_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_req", imem_req_o, 1'b0);
            step(1, 1, 0, 32'h0, 1);
        end
        chk("t6_sticky", misalign_o, 1'b1);
`else
        chk("t6_misalign", misalign_o, 1'b0);
        chk("t6_req", imem_req_o, 1'b1);
        chk("t6_addr", imem_addr_o, 32'h100);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h0, 1);
`endif
        // reset in the middle of fetching (reset values checked inside)
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 1, 0, 32'h0, 3);
        do_reset();

        // randomized traffic, periodic mid-operation resets
        for (int i = 0; i < 2400; i++) begin
            if (i % 400 == 399) do_reset();
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF8;
                1:       tgt = $urandom() & 32'h0000_0FFC;
`ifdef IF_MISALIGN_CHK_EN
                default: tgt = $urandom() & ~32'h3;
`else
                default: tgt = $urandom();
`endif
            endcase
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, tgt, $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
